// File: rtl/err_stats_if.sv
// Handshake bundle for the windowed error-statistics engine: sample/control in, window results out.
interface err_stats_if #(
  parameter int ERR_WID = 18
);
  logic               sym_clk_en;
  logic [ERR_WID-1:0] error;
  logic               start;
  logic               clear;
  logic [ERR_WID-1:0] mean_err;
  logic [ERR_WID-1:0] mse;
  logic               sat;
  logic               valid;
  logic               busy;

  modport master (
    output sym_clk_en, error, start, clear,
    input  mean_err, mse, sat, valid, busy
  );

  modport slave (
    input  sym_clk_en, error, start, clear,
    output mean_err, mse, sat, valid, busy
  );
endinterface

// File: rtl/err_stats_windowed.sv
// Windowed slicer-error statistics: mean error and MSE over 2^LOG2_N symbols,
// two-stage pipeline (square/capture, accumulate/report), continuous or one-shot.
module err_stats_windowed #(
  parameter int ERR_WID    = 18,
  parameter int LOG2_N     = 20,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic        sys_clk,
  input  logic        reset,
  err_stats_if.slave  bus
);
  localparam int AW = ERR_WID + LOG2_N;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              accept, last;

  // clear wins over a coincident sample: the sample is dropped with the window
  assign accept = (state_q == RUN) && bus.sym_clk_en && !bus.clear;
  assign last   = (cnt_q == {LOG2_N{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CONTINUOUS) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    if (bus.start && !bus.clear) state_d = RUN;
        RUN:     if (bus.clear || (accept && last)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (bus.clear)   cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Square term: only error = most-negative reaches bit 2W-2, so that bit is the overflow flag
  logic signed [2*ERR_WID-1:0] err_x, prod;
  logic                        sq_ovf;
  logic [ERR_WID-1:0]          sq_term;
  logic                        unused_prod;

  assign err_x       = {{ERR_WID{bus.error[ERR_WID-1]}}, bus.error};
  assign prod        = err_x * err_x;
  assign sq_ovf      = prod[2*ERR_WID-2];
  assign sq_term     = sq_ovf ? {ERR_WID{1'b1}} : prod[2*ERR_WID-3:ERR_WID-2];
  assign unused_prod = ^{prod[2*ERR_WID-1], prod[ERR_WID-3:0]};

  logic               s1_vld_q, s1_last_q, s1_sat_q;
  logic [ERR_WID-1:0] s1_err_q, s1_sq_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_sat_q  <= 1'b0;
      s1_err_q  <= '0;
      s1_sq_q   <= '0;
    end else if (bus.clear) begin
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_last_q <= last;
        s1_sat_q  <= sq_ovf;
        s1_err_q  <= bus.error;
        s1_sq_q   <= sq_term;
      end
    end
  end

  logic [AW-1:0]      sum_acc_q, sq_acc_q, sum_add, sq_add;
  logic               sat_acc_q;
  logic [ERR_WID-1:0] mean_q, mse_q;
  logic               sat_q, valid_q;

  assign sum_add = sum_acc_q + {{LOG2_N{s1_err_q[ERR_WID-1]}}, s1_err_q};
  assign sq_add  = sq_acc_q + {{LOG2_N{1'b0}}, s1_sq_q};

  // Bits [AW-1:LOG2_N] are the floor shift by LOG2_N; the accumulators restart
  // on the reporting edge so the next window's first sample is not lost.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sum_acc_q <= '0;
      sq_acc_q  <= '0;
      sat_acc_q <= 1'b0;
      mean_q    <= '0;
      mse_q     <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear) begin
        sum_acc_q <= '0;
        sq_acc_q  <= '0;
        sat_acc_q <= 1'b0;
      end else if (s1_vld_q) begin
        if (s1_last_q) begin
          mean_q    <= sum_add[AW-1:LOG2_N];
          mse_q     <= sq_add[AW-1:LOG2_N];
          sat_q     <= sat_acc_q | s1_sat_q;
          valid_q   <= 1'b1;
          sum_acc_q <= '0;
          sq_acc_q  <= '0;
          sat_acc_q <= 1'b0;
        end else begin
          sum_acc_q <= sum_add;
          sq_acc_q  <= sq_add;
          sat_acc_q <= sat_acc_q | s1_sat_q;
        end
      end
    end
  end

  assign bus.mean_err = mean_q;
  assign bus.mse      = mse_q;
  assign bus.sat      = sat_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == RUN) | s1_vld_q;
endmodule

// File: doc/err_stats_windowed.md
# err_stats_windowed

Parametrised windowed error-statistics engine for the receiver's slicer-error path. It accumulates signed slicer error and its square over a programmable window of 2^LOG2_N symbols, and reports the mean error and mean squared error (MSE). An internal symbol counter replaces the external clear strobe, so no free-running LFSR window generator is needed. It is pipelined and runs either back-to-back continuous windows or single windows on request, with saturation reporting.

## Interface

- ERR_WID, 18: error/result width; format 2s(ERR_WID-2), i.e. 2sX with ERR_WID-2 fraction bits.
- LOG2_N, 20: window length is 2^LOG2_N symbols; legal range 1..24.
- CONTINUOUS, 1: 1 = free-running back-to-back windows; 0 = one window per start request.
- sys_clk  in  1  system clock; all logic is single-clock.
- reset  in  1  asynchronous, active-high; clears all state.
- sym_clk_en  in  1  symbol strobe; error is sampled only when high.
- error  in  ERR_WID  signed slicer error, 2s(ERR_WID-2).
- start  in  1  one-shot arm (CONTINUOUS=0 only; ignored otherwise).
- clear  in  1  synchronous abort of the current window.
- mean_err  out  ERR_WID  signed window mean of error, same format as error.
- mse  out  ERR_WID  unsigned window mean of error², format u2.(ERR_WID-2), range [0,4).
- sat  out  1  high if any square term in the reported window saturated.
- valid  out  1  one-cycle strobe: mean_err/mse/sat were updated.
- busy  out  1  high while a window is in progress or the pipeline holds samples.

## Operation

- FSM states: IDLE, RUN.
  - Reset state is IDLE.
  - CONTINUOUS=1: IDLE -> RUN on the first clock after reset deasserts; the block never returns to IDLE except via reset.
  - CONTINUOUS=0: IDLE -> RUN on start=1. RUN -> IDLE after the final sample of the window is accepted. start while in RUN is ignored.
- Sample acceptance: a sample is accepted only in RUN with sym_clk_en=1. The sample counter (LOG2_N bits) increments on each accepted sample. The accepted sample with counter = 2^LOG2_N-1 is tagged "last", and the counter wraps to 0.
- Pipeline stage 1 (registered): captures error and the square term, with a valid bit and a last tag.
  - Square: P = error*error, 2*ERR_WID bits.
  - Term s = P[2*ERR_WID-3 : ERR_WID-2], unsigned.
  - Only P = 2^(2*ERR_WID-2) (error = most-negative value) overflows. In that case s saturates to 2^ERR_WID-1 and a sat bit is set in the stage.
- Stage 2 (accumulate):
  - sum_acc is signed and ERR_WID+LOG2_N bits wide; sq_acc is unsigned and ERR_WID+LOG2_N bits wide. Neither can overflow.
  - sat_acc is a sticky OR of the stage-1 sat bits.
  - On a last-tagged stage-1 entry:
    - mean_err <= (sum_acc+error) >>> LOG2_N (arithmetic, floor), low ERR_WID bits.
    - mse <= (sq_acc+s) >> LOG2_N.
    - sat <= sat_acc | stage sat.
    - valid <= 1.
    - Accumulators and sat_acc reload to 0 at the same edge, so no sample is lost between windows.
- Outputs hold their last values between valid strobes.
- clear=1:
  - Zeros the counter, accumulators, sat_acc and the stage-1 valid bit.
  - Outputs keep their previous values, and valid is not asserted that cycle.
  - CONTINUOUS=1: stays in RUN with a fresh window. CONTINUOUS=0: goes to IDLE.
- Simultaneous events:
  - clear with start: clear wins, and the block stays in IDLE.
  - clear while a last-tagged entry is in stage 1: clear wins, and no valid strobe is produced.
  - sym_clk_en in the cycle after a last sample in CONTINUOUS=1: the sample is accepted as sample 0 of the next window.
- busy = (state==RUN) | stage-1 valid.

## Timing

- Reset values: mean_err=0, mse=0, sat=0, valid=0, busy=0, state IDLE, counter 0, all accumulators 0.
- Reset asserted mid-window discards that window entirely. After release, CONTINUOUS=1 begins a new window one cycle later.
- Latency: a final sample presented with sym_clk_en=1 in cycle k gives valid=1 and updated outputs in cycle k+2, for exactly one cycle.
- Throughput: sym_clk_en may be high every cycle. The minimum window duration is 2^LOG2_N cycles.
- CONTINUOUS=0: busy drops in cycle k+2, together with valid. A start in cycle k+2 or later arms the next window.

## Test plan

- ERR_WID=18, LOG2_N=2, CONTINUOUS=1, error=32768 (0.5) for 4 symbols:
  - Required: valid pulse 2 cycles after the 4th symbol, mean_err=32768, mse=16384, sat=0.
- Same configuration, error alternating +65536/-65536 for 4 symbols:
  - Required: mean_err=0, mse=65536. A second back-to-back window with sym_clk_en every cycle yields its own valid exactly 4 cycles later.
- error=-131072 for 4 symbols:
  - Required: mean_err=-131072, mse=262143, sat=1.
  - The next window with error=0 gives mean_err=0, mse=0, sat=0.
- Floor rounding, errors -1,0,0,0:
  - Required: mean_err=-1 (0x3FFFF), mse=0.
- CONTINUOUS=0 one-shot sequence:
  - No valid and busy=0 before start.
  - start, then 4 symbols: one valid pulse, then busy=0, and further symbols are ignored.
  - clear after 2 symbols: no valid; outputs unchanged.
- Reset asserted asynchronously mid-window (between edges):
  - Required: all outputs are 0 immediately.
  - After release, a full fresh window of 4 symbols is required before the next valid.
